// File: rtl/lvt_ram_pkg.sv
// Shared definitions for the live-value-table multi-port RAM.
// LVT entries are packed {valid, index[LW-1:0]}, valid at the MSB.
package lvt_ram_pkg;

   // Width of a bank index for nw write ports (ceil(log2(nw)), minimum 1 for nw=2).
   function automatic int lvt_lw(input int nw);
      int w;
      w = 0;
      for (int v = nw - 1; v > 0; v = v >> 1) begin
         w++;
      end
      return w;
   endfunction

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } clr_state_t;

endpackage

// File: rtl/lvt_bank_1w_nr.sv
// One-write / NR-read storage bank; reads registered, 1-cycle latency, no backpressure.
// Storage is never reset; a same-cycle read of the written address returns the old word.
module lvt_bank_1w_nr
   import lvt_ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int NR     = 8
) (
   input  logic                   clk,
   input  logic                   w_enb,
   input  logic [ADDR_W-1:0]      w_addr,
   input  logic [DATA_W-1:0]      w_din,
   input  logic [NR*ADDR_W-1:0]   r_addr,
   output logic [NR*DATA_W-1:0]   r_dout
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (w_enb) begin
         mem[w_addr] <= w_din;
      end
      for (int j = 0; j < NR; j++) begin
         r_dout[j*DATA_W +: DATA_W] <= mem[r_addr[j*ADDR_W +: ADDR_W]];
      end
   end

endmodule

// File: rtl/lvt_ram_nrmw.sv
// NW-write / NR-read RAM from per-port banks plus a live-value table; reads 1-cycle latency.
// No backpressure: writes are dropped and reads return 0 until the post-reset LVT sweep ends.
module lvt_ram_nrmw
   import lvt_ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int NR     = 8,
   parameter int NW     = 4,
   parameter int BYPASS = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NW-1:0]          w_enb,
   input  logic [NW*ADDR_W-1:0]   w_addr,
   input  logic [NW*DATA_W-1:0]   w_din,
   input  logic [NR*ADDR_W-1:0]   r_addr,
   output logic [NR*DATA_W-1:0]   r_dout,
   output logic                   ready,
   output logic                   w_conflict
);

   localparam int LW    = lvt_lw(NW);
   localparam int EW    = LW + 1;
   localparam int DEPTH = 1 << ADDR_W;

   clr_state_t          state;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [EW-1:0]       lvt [DEPTH];
   logic [NW-1:0]       w_act;
   logic                conf;

   logic [NR*DATA_W-1:0] bank_dout [NW];

   logic [NR-1:0]        byp_hit;
   logic [DATA_W-1:0]    byp_dat   [NR];
   logic [NR-1:0]        rd_vld_q;
   logic [LW-1:0]        rd_sel_q  [NR];
   logic [NR-1:0]        byp_hit_q;
   logic [DATA_W-1:0]    byp_dat_q [NR];

   assign w_act = ready ? w_enb : '0;

   // Clear sweep: one LVT entry per cycle, then park in RUN until the next reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + ADDR_W'(1);
               if (clr_cnt == {ADDR_W{1'b1}}) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               state <= RUN;
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

   // Ascending loop lets the highest-indexed port's entry land last and win.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         lvt[clr_cnt] <= '0;
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (w_act[i]) begin
               lvt[w_addr[i*ADDR_W +: ADDR_W]] <= {1'b1, LW'(i)};
            end
         end
      end
   end

   generate
      for (genvar k = 0; k < NW; k++) begin : g_bank
         lvt_bank_1w_nr #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NR     (NR)
         ) u_bank (
            .clk    (clk),
            .w_enb  (w_act[k]),
            .w_addr (w_addr[k*ADDR_W +: ADDR_W]),
            .w_din  (w_din[k*DATA_W +: DATA_W]),
            .r_addr (r_addr),
            .r_dout (bank_dout[k])
         );
      end
   endgenerate

   always_comb begin
      conf = 1'b0;
      for (int i = 0; i < NW; i++) begin
         for (int k = i + 1; k < NW; k++) begin
            if (w_act[i] && w_act[k] &&
                (w_addr[i*ADDR_W +: ADDR_W] == w_addr[k*ADDR_W +: ADDR_W])) begin
               conf = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int j = 0; j < NR; j++) begin
         byp_hit[j] = 1'b0;
         byp_dat[j] = '0;
         for (int i = 0; i < NW; i++) begin
            if (w_act[i] && (w_addr[i*ADDR_W +: ADDR_W] == r_addr[j*ADDR_W +: ADDR_W])) begin
               byp_hit[j] = 1'b1;
               byp_dat[j] = w_din[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // LVT lookup is registered alongside the bank reads so the select lines up with bank data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_conflict <= 1'b0;
         rd_vld_q   <= '0;
         byp_hit_q  <= '0;
         for (int j = 0; j < NR; j++) begin
            rd_sel_q[j]  <= '0;
            byp_dat_q[j] <= '0;
         end
      end else begin
         w_conflict <= conf;
         for (int j = 0; j < NR; j++) begin
            rd_vld_q[j]  <= ready & lvt[r_addr[j*ADDR_W +: ADDR_W]][LW];
            rd_sel_q[j]  <= lvt[r_addr[j*ADDR_W +: ADDR_W]][LW-1:0];
            byp_hit_q[j] <= (BYPASS != 0) && byp_hit[j];
            byp_dat_q[j] <= byp_dat[j];
         end
      end
   end

   always_comb begin
      r_dout = '0;
      for (int j = 0; j < NR; j++) begin
         if (byp_hit_q[j]) begin
            r_dout[j*DATA_W +: DATA_W] = byp_dat_q[j];
         end else if (rd_vld_q[j]) begin
            for (int k = 0; k < NW; k++) begin
               if (rd_sel_q[j] == LW'(k)) begin
                  r_dout[j*DATA_W +: DATA_W] = bank_dout[k][j*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lvt_ram_nrmw.sv
// Bench for lvt_ram_nrmw: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// checked against a flat reference memory through a read scoreboard.
module tb_lvt_ram_nrmw;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int NR     = 8;
   localparam int NW     = 4;
   localparam int SWEEP  = 1 << ADDR_W;

   logic                  clk;
   logic                  rst;
   logic [NW-1:0]         w_enb;
   logic [NW*ADDR_W-1:0]  w_addr;
   logic [NW*DATA_W-1:0]  w_din;
   logic [NR*ADDR_W-1:0]  r_addr;
   logic [NR*DATA_W-1:0]  r_dout1, r_dout0;
   logic                  ready1, ready0;
   logic                  conf1, conf0;

   lvt_ram_nrmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW), .BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
      .r_addr(r_addr), .r_dout(r_dout1), .ready(ready1), .w_conflict(conf1));

   lvt_ram_nrmw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
      .r_addr(r_addr), .r_dout(r_dout0), .ready(ready0), .w_conflict(conf0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [31:0] e1;
      logic [31:0] e0;
   } exp_t;

   typedef struct {
      logic [3:0]   wen;
      logic [15:0]  wa;
      logic [127:0] wd;
      logic [31:0]  ra;
      logic         conf;
   } vec_t;

   exp_t        sb [$];
   vec_t        tbl [7];
   logic [31:0] ref_data [SWEEP];
   logic        ref_vld  [SWEEP];
   int          cycles;
   int          n_tests;
   int          n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] wa1(input int port, input logic [3:0] a);
      logic [15:0] v;
      v = '0;
      v[port*4 +: 4] = a;
      return v;
   endfunction

   function automatic logic [127:0] wd1(input int port, input logic [31:0] d);
      logic [127:0] v;
      v = '0;
      v[port*32 +: 32] = d;
      return v;
   endfunction

   function automatic logic [31:0] rd1(input logic [255:0] dout, input int port);
      return dout[port*32 +: 32];
   endfunction

   task automatic do_reset();
      rst    = 1'b1;
      w_enb  = '0;
      #1;
      chk("rst_ready_b1", 32'(ready1), 32'd0);
      chk("rst_ready_b0", 32'(ready0), 32'd0);
      chk("rst_conf", 32'({conf1, conf0}), 32'd0);
      chk("rst_dout", 32'(|{r_dout1, r_dout0}), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      cycles = 0;
      for (int a = 0; a < SWEEP; a++) begin
         ref_vld[a]  = 1'b0;
         ref_data[a] = '0;
      end
   endtask

   // One clock of stimulus; read expectations are queued before the edge and drained after it.
   task automatic step(input logic [3:0] wen, input logic [15:0] wa, input logic [127:0] wd,
                       input logic [31:0] ra, input logic exp_conf);
      logic       mrdy;
      logic [3:0] a;
      exp_t       e;
      mrdy   = (cycles >= SWEEP);
      w_enb  = wen;
      w_addr = wa;
      w_din  = wd;
      r_addr = ra;
      for (int j = 0; j < NR; j++) begin
         a      = ra[j*4 +: 4];
         e.port = j;
         e.e0   = (mrdy && ref_vld[a]) ? ref_data[a] : 32'd0;
         e.e1   = e.e0;
         if (mrdy) begin
            for (int i = 0; i < NW; i++) begin
               if (wen[i] && (wa[i*4 +: 4] == a)) e.e1 = wd[i*32 +: 32];
            end
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cycles++;
      if (mrdy) begin
         for (int i = 0; i < NW; i++) begin
            if (wen[i]) begin
               ref_data[wa[i*4 +: 4]] = wd[i*32 +: 32];
               ref_vld[wa[i*4 +: 4]]  = 1'b1;
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("rd_byp1_p%0d", e.port), rd1(r_dout1, e.port), e.e1);
         chk($sformatf("rd_byp0_p%0d", e.port), rd1(r_dout0, e.port), e.e0);
      end
      chk("conflict_b1", 32'(conf1), 32'(mrdy & exp_conf));
      chk("conflict_b0", 32'(conf0), 32'(mrdy & exp_conf));
      chk("ready_b1", 32'(ready1), 32'(cycles >= SWEEP));
      chk("ready_b0", 32'(ready0), 32'(cycles >= SWEEP));
      w_enb = '0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cycles  = 0;
      w_enb   = '0;
      w_addr  = '0;
      w_din   = '0;
      r_addr  = '0;

      tbl[0] = '{4'b0001, 16'h000A, {32'h0, 32'h0, 32'h0, 32'h100},   32'hAAAA_AAAA, 1'b0};
      tbl[1] = '{4'b1111, 16'h4321, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 32'h0123_4A98, 1'b0};
      tbl[2] = '{4'b0110, 16'h0660, {32'h0, 32'h222, 32'h111, 32'h0}, 32'h6666_6666, 1'b1};
      tbl[3] = '{4'b1001, 16'hF00F, {32'h3F, 32'h0, 32'h0, 32'h0F},   32'hF0F0_F0F0, 1'b1};
      tbl[4] = '{4'b0000, 16'h0000, 128'h0,                            32'hFEDC_BA98, 1'b0};
      tbl[5] = '{4'b1111, 16'h0000, {32'h4, 32'h3, 32'h2, 32'h1},     32'h0123_4567, 1'b1};
      tbl[6] = '{4'b0000, 16'h0000, 128'h0,                            32'h7654_3210, 1'b0};

      // Sweep: ready low for exactly SWEEP cycles, writes dropped, reads of addr 3 are 0.
      do_reset();
      for (int c = 0; c < SWEEP; c++) begin
         step(4'b0001, wa1(0, 4'd3), wd1(0, 32'h99), 32'h3333_3333, 1'b0);
      end
      step(4'b0000, 16'h0, 128'h0, 32'h3333_3333, 1'b0);
      chk("sweep_write_dropped", rd1(r_dout1, 0), 32'h0);

      // Basic write then broadcast read.
      step(4'b0100, wa1(2, 4'd5), wd1(2, 32'hDEADBEEF), 32'h0, 1'b0);
      step(4'b0000, 16'h0, 128'h0, 32'h5555_5555, 1'b0);
      for (int j = 0; j < NR; j++) begin
         chk($sformatf("basic_p%0d", j), rd1(r_dout1, j), 32'hDEADBEEF);
      end

      // Last writer across cycles.
      step(4'b0001, wa1(0, 4'd7), wd1(0, 32'h11), 32'h0, 1'b0);
      step(4'b1000, wa1(3, 4'd7), wd1(3, 32'h33), 32'h0, 1'b0);
      step(4'b0000, 16'h0, 128'h0, 32'h0000_0007, 1'b0);
      chk("last_writer", rd1(r_dout0, 0), 32'h33);

      // Same-cycle conflict: higher port wins, pulse lasts one cycle.
      step(4'b1010, 16'h9090, {32'hBB, 32'h0, 32'hAA, 32'h0}, 32'h0, 1'b1);
      chk("conflict_pulse", 32'(conf1), 32'd1);
      step(4'b0000, 16'h0, 128'h0, 32'h9999_9999, 1'b0);
      chk("conflict_winner", rd1(r_dout1, 3), 32'hBB);

      // Read/write collision.
      step(4'b0001, wa1(0, 4'd12), wd1(0, 32'h01), 32'h0, 1'b0);
      step(4'b0001, wa1(0, 4'd12), wd1(0, 32'h02), 32'h000C_0000, 1'b0);
      chk("bypass_on", rd1(r_dout1, 4), 32'h02);
      chk("bypass_off", rd1(r_dout0, 4), 32'h01);

      for (int t = 0; t < 7; t++) begin
         step(tbl[t].wen, tbl[t].wa, tbl[t].wd, tbl[t].ra, tbl[t].conf);
      end

      // Reset mid-run: prior data disappears, sweep writes dropped.
      step(4'b0001, wa1(0, 4'd2), wd1(0, 32'h55), 32'h0, 1'b0);
      do_reset();
      for (int c = 0; c < SWEEP; c++) begin
         step(4'b0010, wa1(1, 4'd2), wd1(1, 32'h77), 32'h2222_2222, 1'b0);
      end
      step(4'b0000, 16'h0, 128'h0, 32'h2222_2222, 1'b0);
      chk("rst_mid_run_b1", rd1(r_dout1, 0), 32'h0);
      chk("rst_mid_run_b0", rd1(r_dout0, 7), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
